// File: rtl/caesar_sram_pkg.sv
// Shared types and helpers for the Caesar banked SRAM controller.
package caesar_sram_pkg;

    typedef enum logic [1:0] {
        ACTIVE,
        DRAIN,
        RETENTION,
        WAKE
    } pwr_state_e;

    // A single bank needs no select bits at all, so the row takes the whole address.
    function automatic int bank_sel_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 0;
    endfunction

endpackage

// File: rtl/caesar_banked_sram_ctrl_if.sv
// Request/grant/read-valid bus plus retention handshake between the bus adapter and the controller.
interface caesar_banked_sram_ctrl_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) ();

    logic                    req;
    logic                    gnt;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] be;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    ret_req;
    logic                    ret_ack;
    logic                    busy;

    modport master (
        output req, we, addr, wdata, be, ret_req,
        input  gnt, rvalid, rdata, ret_ack, busy
    );

    modport slave (
        input  req, we, addr, wdata, be, ret_req,
        output gnt, rvalid, rdata, ret_ack, busy
    );

endinterface

// File: rtl/caesar_sram_pwr_fsm.sv
// Power sequencer: ACTIVE -> DRAIN -> RETENTION -> WAKE -> ACTIVE, with idle-triggered entry
// and a fixed wake-up delay before grants resume.
module caesar_sram_pwr_fsm
    import caesar_sram_pkg::*;
#(
    parameter int RET_WAKE_CYCLES = 4,
    parameter int AUTO_RET_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ret_req,
    input  logic rd_pending,
    output logic active,
    output logic ret_ack,
    output logic set_retentive_n
);

    localparam bit AutoEn = (AUTO_RET_CYCLES > 0);
    localparam int IdleW  = (AUTO_RET_CYCLES > 1) ? $clog2(AUTO_RET_CYCLES) : 1;
    localparam int WakeW  = (RET_WAKE_CYCLES > 1) ? $clog2(RET_WAKE_CYCLES) : 1;
    localparam logic [IdleW-1:0] IdleLast = IdleW'(AutoEn ? AUTO_RET_CYCLES - 1 : 0);
    localparam logic [WakeW-1:0] WakeLast = WakeW'(RET_WAKE_CYCLES - 1);

    pwr_state_e       state_q, state_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [WakeW-1:0] wake_q, wake_d;
    logic             explicit_q, explicit_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACTIVE;
            idle_q     <= '0;
            wake_q     <= '0;
            explicit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_q     <= idle_d;
            wake_q     <= wake_d;
            explicit_q <= explicit_d;
        end
    end

    // explicit_q remembers why retention was entered: an auto entry only wakes on a real request.
    always_comb begin
        state_d    = state_q;
        idle_d     = '0;
        wake_d     = '0;
        explicit_d = explicit_q;
        case (state_q)
            ACTIVE: begin
                if (ret_req) begin
                    state_d    = DRAIN;
                    explicit_d = 1'b1;
                end else if (!req && AutoEn) begin
                    if (idle_q == IdleLast) begin
                        state_d    = DRAIN;
                        explicit_d = 1'b0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!rd_pending) state_d = RETENTION;
            end
            RETENTION: begin
                if (!ret_req && (req || explicit_q)) state_d = WAKE;
            end
            WAKE: begin
                if (wake_q == WakeLast) state_d = ACTIVE;
                else                    wake_d  = wake_q + 1'b1;
            end
            default: state_d = ACTIVE;
        endcase
    end

    assign active          = (state_q == ACTIVE);
    assign ret_ack         = (state_q == RETENTION);
    assign set_retentive_n = (state_q != RETENTION);

endmodule

// File: rtl/sram_wrapper.sv
// Behavioural stand-in for one hard SRAM macro: 1-cycle read latency, byte-enabled writes,
// contents kept through retention but no access while set_retentive_n is low.
module sram_wrapper #(
    parameter int NUM_WORDS  = 1024,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         req,
    input  logic                         we,
    input  logic [$clog2(NUM_WORDS)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH/8-1:0]      be,
    input  logic                         set_retentive_n,
    output logic [DATA_WIDTH-1:0]        rdata
);

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

    always_ff @(posedge clk) begin
        if (req && set_retentive_n) begin
            if (we) begin
                for (int i = 0; i < DATA_WIDTH/8; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/caesar_banked_sram_ctrl.sv
// Word-interleaved multi-bank SRAM controller: low address bits pick the bank, reads return
// one cycle after the grant through a registered bank-select mux.
module caesar_banked_sram_ctrl
    import caesar_sram_pkg::*;
#(
    parameter int NUM_WORDS       = 1024,
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_BANKS       = 2,
    parameter int RET_WAKE_CYCLES = 4,
    parameter int AUTO_RET_CYCLES = 0
) (
    input logic                      clk,
    input logic                      rst,
    caesar_banked_sram_ctrl_if.slave bus
);

    localparam int BankSelW  = bank_sel_w(NUM_BANKS);
    localparam int RowW      = $clog2(NUM_WORDS);
    localparam int AddrWidth = RowW + BankSelW;
    localparam int IdxW      = (BankSelW > 0) ? BankSelW : 1;

    logic                  active;
    logic                  ret_n;
    logic [IdxW-1:0]       bank_sel;
    logic [IdxW-1:0]       rd_bank_q;
    logic [RowW-1:0]       row;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_hold_q;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic [NUM_BANKS-1:0]  bank_ret_n;

    assign bus.gnt = bus.req & active & ~bus.ret_req;
    assign row     = bus.addr[AddrWidth-1:BankSelW];

    generate
        if (NUM_BANKS > 1) begin : g_sel
            assign bank_sel = bus.addr[BankSelW-1:0];
        end else begin : g_nosel
            assign bank_sel = '0;
        end

        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic bank_req;
            assign bank_req      = bus.gnt & (bank_sel == IdxW'(b));
            assign bank_ret_n[b] = ret_n;

            sram_wrapper #(
                .NUM_WORDS  (NUM_WORDS),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_sram (
                .clk             (clk),
                .req             (bank_req),
                .we              (bus.we),
                .addr            (row),
                .wdata           (bus.wdata),
                .be              (bus.be),
                .set_retentive_n (bank_ret_n[b]),
                .rdata           (bank_rdata[b])
            );
        end
    endgenerate

    // rdata_hold_q keeps the last returned word visible once rvalid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q     <= 1'b0;
            rd_bank_q    <= '0;
            rdata_hold_q <= '0;
        end else begin
            rvalid_q <= bus.gnt & ~bus.we;
            if (bus.gnt && !bus.we) rd_bank_q    <= bank_sel;
            if (rvalid_q)           rdata_hold_q <= bank_rdata[rd_bank_q];
        end
    end

    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rvalid_q ? bank_rdata[rd_bank_q] : rdata_hold_q;
    assign bus.busy   = ~active | rvalid_q;

    caesar_sram_pwr_fsm #(
        .RET_WAKE_CYCLES (RET_WAKE_CYCLES),
        .AUTO_RET_CYCLES (AUTO_RET_CYCLES)
    ) u_pwr (
        .clk             (clk),
        .rst             (rst),
        .req             (bus.req),
        .ret_req         (bus.ret_req),
        .rd_pending      (rvalid_q),
        .active          (active),
        .ret_ack         (bus.ret_ack),
        .set_retentive_n (ret_n)
    );

endmodule

// File: tb/tb_caesar_banked_sram_ctrl.sv
// Directed bench: dut0 has auto-retention disabled, dut1 enters retention after 8 idle cycles.
module tb_caesar_banked_sram_ctrl;
    import caesar_sram_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    caesar_banked_sram_ctrl_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) bus0 ();
    caesar_banked_sram_ctrl_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) bus1 ();

    caesar_banked_sram_ctrl #(
        .NUM_WORDS(1024), .DATA_WIDTH(32), .NUM_BANKS(2),
        .RET_WAKE_CYCLES(4), .AUTO_RET_CYCLES(0)
    ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    caesar_banked_sram_ctrl #(
        .NUM_WORDS(1024), .DATA_WIDTH(32), .NUM_BANKS(2),
        .RET_WAKE_CYCLES(4), .AUTO_RET_CYCLES(8)
    ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0.req = 0; bus0.we = 0; bus0.addr = '0; bus0.wdata = '0; bus0.be = '0; bus0.ret_req = 0;
        bus1.req = 0; bus1.we = 0; bus1.addr = '0; bus1.wdata = '0; bus1.be = '0; bus1.ret_req = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (bus0.gnt !== 1'b0) begin errors++; $display("[TB] FAIL rst_gnt got %0b want 0", bus0.gnt); end
        checks++; if (bus0.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_rvalid got %0b want 0", bus0.rvalid); end
        checks++; if (bus0.rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_rdata got %h want 0", bus0.rdata); end
        checks++; if (bus0.ret_ack !== 1'b0) begin errors++; $display("[TB] FAIL rst_ret_ack got %0b want 0", bus0.ret_ack); end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %0b want 0", bus0.busy); end
    endtask

    task automatic test_reset_mid_wake();
        bus0.ret_req = 1'b1;
        repeat (2) step();
        checks++; if (bus0.ret_ack !== 1'b1) begin errors++; $display("[TB] FAIL mw_ret_ack got %0b want 1", bus0.ret_ack); end
        checks++; if (dut0.bank_ret_n !== 2'b00) begin errors++; $display("[TB] FAIL mw_ret_n_low got %b want 00", dut0.bank_ret_n); end
        bus0.ret_req = 1'b0;
        repeat (2) step();
        checks++; if (dut0.u_pwr.state_q !== WAKE) begin errors++; $display("[TB] FAIL mw_in_wake got %0d want %0d", dut0.u_pwr.state_q, WAKE); end
        checks++; if (bus0.busy !== 1'b1) begin errors++; $display("[TB] FAIL mw_busy_wake got %0b want 1", bus0.busy); end
        rst = 1'b1;
        #1;
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("[TB] FAIL mw_busy_rst got %0b want 0", bus0.busy); end
        checks++; if (dut0.bank_ret_n !== 2'b11) begin errors++; $display("[TB] FAIL mw_ret_n_rst got %b want 11", dut0.bank_ret_n); end
        step();
        rst = 1'b0;
        bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 11'd7; bus0.wdata = 32'h0; bus0.be = 4'hF;
        #1;
        checks++; if (dut0.u_pwr.state_q !== ACTIVE) begin errors++; $display("[TB] FAIL mw_state_active got %0d want %0d", dut0.u_pwr.state_q, ACTIVE); end
        checks++; if (bus0.gnt !== 1'b1) begin errors++; $display("[TB] FAIL mw_gnt_after got %0b want 1", bus0.gnt); end
        step();
        bus0.req = 1'b0; bus0.we = 1'b0;
    endtask

    task automatic test_interleave();
        step();
        bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 11'd0; bus0.wdata = 32'hDEADBEEF; bus0.be = 4'hF;
        #1;
        checks++; if (bus0.gnt !== 1'b1) begin errors++; $display("[TB] FAIL il_gnt_w0 got %0b want 1", bus0.gnt); end
        step();
        bus0.addr = 11'd1; bus0.wdata = 32'h12345678;
        #1;
        checks++; if (bus0.gnt !== 1'b1) begin errors++; $display("[TB] FAIL il_gnt_w1 got %0b want 1", bus0.gnt); end
        step();
        bus0.we = 1'b0; bus0.addr = 11'd0;
        #1;
        checks++; if (bus0.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL il_no_rvalid_wr got %0b want 0", bus0.rvalid); end
        step();
        bus0.addr = 11'd1;
        #1;
        checks++; if (bus0.gnt !== 1'b1) begin errors++; $display("[TB] FAIL il_gnt_r1 got %0b want 1", bus0.gnt); end
        checks++; if (bus0.rvalid !== 1'b1) begin errors++; $display("[TB] FAIL il_rvalid0 got %0b want 1", bus0.rvalid); end
        checks++; if (bus0.rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL il_rdata0 got %h want deadbeef", bus0.rdata); end
        step();
        bus0.req = 1'b0;
        #1;
        checks++; if (bus0.rvalid !== 1'b1) begin errors++; $display("[TB] FAIL il_rvalid1 got %0b want 1", bus0.rvalid); end
        checks++; if (bus0.rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL il_rdata1 got %h want 12345678", bus0.rdata); end
        step();
        checks++; if (bus0.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL il_rvalid_drop got %0b want 0", bus0.rvalid); end
        checks++; if (bus0.rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL il_rdata_hold got %h want 12345678", bus0.rdata); end
    endtask

    task automatic test_byte_enable();
        bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 11'd5; bus0.wdata = 32'hFFFFFFFF; bus0.be = 4'hF;
        #1;
        checks++; if (bus0.gnt !== 1'b1) begin errors++; $display("[TB] FAIL be_gnt_full got %0b want 1", bus0.gnt); end
        step();
        bus0.wdata = 32'h00000000; bus0.be = 4'b0010;
        step();
        bus0.we = 1'b0; bus0.be = 4'h0;
        step();
        bus0.req = 1'b0;
        #1;
        checks++; if (bus0.rvalid !== 1'b1) begin errors++; $display("[TB] FAIL be_rvalid got %0b want 1", bus0.rvalid); end
        checks++; if (bus0.rdata !== 32'hFFFF00FF) begin errors++; $display("[TB] FAIL be_rdata got %h want ffff00ff", bus0.rdata); end
    endtask

    task automatic test_retention_entry();
        step();
        bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 11'd0;
        #1;
        checks++; if (bus0.gnt !== 1'b1) begin errors++; $display("[TB] FAIL re_gnt_read got %0b want 1", bus0.gnt); end
        step();
        bus0.ret_req = 1'b1; bus0.addr = 11'd1;
        #1;
        checks++; if (bus0.gnt !== 1'b0) begin errors++; $display("[TB] FAIL re_gnt_blocked got %0b want 0", bus0.gnt); end
        checks++; if (bus0.rvalid !== 1'b1) begin errors++; $display("[TB] FAIL re_rvalid got %0b want 1", bus0.rvalid); end
        checks++; if (bus0.rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL re_rdata got %h want deadbeef", bus0.rdata); end
        step();
        checks++; if (bus0.ret_ack !== 1'b0 || bus0.busy !== 1'b1) begin errors++; $display("[TB] FAIL re_drain got ack=%0b busy=%0b want ack=0 busy=1", bus0.ret_ack, bus0.busy); end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (bus0.ret_ack !== 1'b1 || bus0.gnt !== 1'b0) begin errors++; $display("[TB] FAIL re_ret_%0d got ack=%0b gnt=%0b want ack=1 gnt=0", k, bus0.ret_ack, bus0.gnt); end
        end
    endtask

    task automatic test_wake();
        bus0.ret_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (bus0.gnt !== 1'b0) begin errors++; $display("[TB] FAIL wk_gnt_early_%0d got %0b want 0", k, bus0.gnt); end
        end
        step();
        checks++; if (bus0.gnt !== 1'b1) begin errors++; $display("[TB] FAIL wk_first_gnt got %0b want 1", bus0.gnt); end
        step();
        bus0.addr = 11'd0;
        #1;
        checks++; if (bus0.rvalid !== 1'b1 || bus0.rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL wk_rdata1 got v=%0b %h want v=1 12345678", bus0.rvalid, bus0.rdata); end
        step();
        bus0.req = 1'b0;
        #1;
        checks++; if (bus0.rvalid !== 1'b1 || bus0.rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wk_rdata0 got v=%0b %h want v=1 deadbeef", bus0.rvalid, bus0.rdata); end
    endtask

    task automatic test_auto_retention();
        rst = 1'b1;
        #1 rst = 1'b0;
        step();
        bus1.req = 1'b1; bus1.we = 1'b1; bus1.addr = 11'd3; bus1.wdata = 32'hCAFEF00D; bus1.be = 4'hF;
        #1;
        checks++; if (bus1.gnt !== 1'b1) begin errors++; $display("[TB] FAIL ar_gnt_wr got %0b want 1", bus1.gnt); end
        for (int i = 1; i <= 8; i++) begin
            step();
            bus1.req = 1'b0; bus1.we = 1'b0;
            #1;
            checks++; if (bus1.busy !== 1'b0) begin errors++; $display("[TB] FAIL ar_idle_%0d got busy=%0b want 0", i, bus1.busy); end
        end
        step();
        checks++; if (bus1.busy !== 1'b1 || bus1.ret_ack !== 1'b0) begin errors++; $display("[TB] FAIL ar_drain got busy=%0b ack=%0b want busy=1 ack=0", bus1.busy, bus1.ret_ack); end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (bus1.ret_ack !== 1'b1) begin errors++; $display("[TB] FAIL ar_ret_%0d got %0b want 1", k, bus1.ret_ack); end
        end
        bus1.req = 1'b1; bus1.we = 1'b0; bus1.addr = 11'd3;
        #1;
        checks++; if (bus1.gnt !== 1'b0) begin errors++; $display("[TB] FAIL ar_gnt_ret got %0b want 0", bus1.gnt); end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (bus1.gnt !== 1'b0) begin errors++; $display("[TB] FAIL ar_gnt_wake_%0d got %0b want 0", k, bus1.gnt); end
        end
        step();
        checks++; if (bus1.gnt !== 1'b1) begin errors++; $display("[TB] FAIL ar_first_gnt got %0b want 1", bus1.gnt); end
        step();
        bus1.req = 1'b0;
        #1;
        checks++; if (bus1.rvalid !== 1'b1 || bus1.rdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL ar_rdata got v=%0b %h want v=1 cafef00d", bus1.rvalid, bus1.rdata); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_reset_mid_wake();
        test_interleave();
        test_byte_enable();
        test_retention_entry();
        test_wake();
        test_auto_retention();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
